mult_accum: RTL and testbench

Accumulation stage placed directly downstream of the 32x32 `Multiplier`. It consumes the multiplier's 64-bit `prod`/`valid` stream, sums a programmable-length burst of products into a wide accumulator, and presents the total on a valid/ready output handshake. It turns the standalone multiplier into the back end of a multiply-accumulate (dot-product) path.

---
 rtl/mult_accum.sv | 148 ++++++++++++++
 tb/tb_mult_accum.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_accum.sv
// mult_accum: accumulation back end for the 32x32 Multiplier.
// Sums a programmable-length burst of unsigned products into a wide
// accumulator and presents the total on a valid/ready handshake.
//
// Ports:
//   clk        - single clock, all state changes on its rising edge
//   reset      - synchronous active-high reset
//   prod       - unsigned product from the multiplier (PROD_W bits)
//   valid      - prod is valid this cycle (no back-pressure upstream)
//   burst_len  - products per burst, 0 means 2^LEN_W; sampled on first product
//   acc_clear  - synchronous abort/clear of the current burst
//   acc_out    - accumulated sum (ACC_W bits)
//   acc_valid  - acc_out holds a completed burst
//   acc_ready  - consumer accepts acc_out
//   ovf        - sticky carry-out of the accumulator within the burst
//   lost       - sticky: a product arrived while a result was pending
//   busy       - a burst is in progress (collecting or waiting for handshake)
module mult_accum #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72,  // must be >= PROD_W
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PROD_W-1:0] prod,
  input  logic              valid,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              acc_clear,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              ovf,
  output logic              lost,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [ACC_W-1:0]   acc_r, acc_nxt_s;
  logic [LEN_W-1:0]   rem_r, rem_nxt_s;
  logic               ovf_r, ovf_nxt_s;
  logic               lost_r, lost_nxt_s;
  logic               acc_valid_r;
  logic               busy_r;
  // One extra bit on top of the accumulator captures the carry-out.
  logic [ACC_W:0]     sum_s;

  // Next-state, next-accumulator and sticky-flag logic.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    rem_nxt_s   = rem_r;
    ovf_nxt_s   = ovf_r;
    lost_nxt_s  = lost_r;
    sum_s       = {1'b0, acc_r} + (ACC_W+1)'(prod);

    if (acc_clear) begin
      // Abort wins over everything except reset; a coincident valid is
      // simply discarded and does not count as lost.
      state_nxt_s = IDLE;
      acc_nxt_s   = '0;
      rem_nxt_s   = '0;
      ovf_nxt_s   = 1'b0;
      lost_nxt_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (valid) begin
            acc_nxt_s = ACC_W'(prod);
            ovf_nxt_s = 1'b0;
            // burst_len==0 wraps to all-ones, giving 2^LEN_W products.
            rem_nxt_s = burst_len - LEN_W'(1);
            if (burst_len == LEN_W'(1)) begin
              state_nxt_s = DONE;
            end else begin
              state_nxt_s = ACCUM;
            end
          end else begin
            state_nxt_s = IDLE;
          end
        end
        ACCUM: begin
          if (valid) begin
            acc_nxt_s = sum_s[ACC_W-1:0];
            ovf_nxt_s = ovf_r | sum_s[ACC_W];
            if (rem_r == LEN_W'(1)) begin
              state_nxt_s = DONE;
            end else begin
              rem_nxt_s = rem_r - LEN_W'(1);
            end
          end else begin
            state_nxt_s = ACCUM;
          end
        end
        DONE: begin
          // The result is frozen; anything arriving now is dropped.
          if (valid) begin
            lost_nxt_s = 1'b1;
          end else begin
            lost_nxt_s = lost_r;
          end
          if (acc_ready) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DONE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State and output registers; status flags are decoded from the next
  // state so that they are registered alongside acc_out and ovf.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      acc_r       <= '0;
      rem_r       <= '0;
      ovf_r       <= 1'b0;
      lost_r      <= 1'b0;
      acc_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      acc_r       <= acc_nxt_s;
      rem_r       <= rem_nxt_s;
      ovf_r       <= ovf_nxt_s;
      lost_r      <= lost_nxt_s;
      acc_valid_r <= (state_nxt_s == DONE);
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  assign acc_out   = acc_r;
  assign acc_valid = acc_valid_r;
  assign ovf       = ovf_r;
  assign lost      = lost_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mult_accum.sv
// Testbench for mult_accum: a default 72-bit instance and a 64-bit
// accumulator instance share one stimulus stream. A directed table, a few
// hand-written sequences and a randomized run are checked; every cycle both
// instances are also compared against a burst-level reference model.
module tb_mult_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        acc_clear = 1'b0;
  logic        valid = 1'b0;
  logic        acc_ready = 1'b0;
  logic [63:0] prod = 64'd0;
  logic [7:0]  burst_len = 8'd1;

  logic [71:0] acc_out;
  logic        acc_valid, ovf, lost, busy;
  logic [63:0] acc_out64;
  logic        acc_valid64, ovf64, lost64, busy64;

  mult_accum dut (
    .clk(clk), .reset(reset), .prod(prod), .valid(valid),
    .burst_len(burst_len), .acc_clear(acc_clear), .acc_out(acc_out),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .ovf(ovf), .lost(lost),
    .busy(busy)
  );

  mult_accum #(.PROD_W(64), .ACC_W(64), .LEN_W(8)) dut64 (
    .clk(clk), .reset(reset), .prod(prod), .valid(valid),
    .burst_len(burst_len), .acc_clear(acc_clear), .acc_out(acc_out64),
    .acc_valid(acc_valid64), .acc_ready(acc_ready), .ovf(ovf64),
    .lost(lost64), .busy(busy64)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: true (unbounded) sum of the products accepted in the
  // current burst, how many were accepted, and how many the burst needs.
  // Overflow is "true sum does not fit in the accumulator".
  logic [79:0] m_sum = 80'd0;
  int          m_cnt = 0;
  int          m_target = 0;
  bit          m_active = 1'b0;
  bit          m_done = 1'b0;
  bit          m_lost = 1'b0;

  task automatic model_update(input logic r, input logic c, input logic v,
                              input logic [63:0] p, input logic [7:0] bl,
                              input logic rd);
    if (r || c) begin
      m_sum = 80'd0; m_cnt = 0; m_target = 0;
      m_active = 1'b0; m_done = 1'b0; m_lost = 1'b0;
    end else if (m_done) begin
      if (v) m_lost = 1'b1;
      if (rd) begin
        m_done = 1'b0;
        m_active = 1'b0;
      end
    end else if (v) begin
      if (!m_active) begin
        m_active = 1'b1;
        m_sum = {16'd0, p};
        m_cnt = 1;
        m_target = (bl == 8'd0) ? 256 : int'(bl);
      end else begin
        m_sum = m_sum + {16'd0, p};
        m_cnt++;
      end
      if (m_cnt == m_target) m_done = 1'b1;
    end
  endtask

  task automatic model_check();
    chk("model acc_valid", {79'd0, acc_valid}, {79'd0, m_done});
    chk("model busy", {79'd0, busy}, {79'd0, m_active});
    chk("model lost", {79'd0, lost}, {79'd0, m_lost});
    chk("model acc_out", {8'd0, acc_out}, {8'd0, m_sum[71:0]});
    chk("model ovf", {79'd0, ovf}, {79'd0, (|m_sum[79:72])});
    chk("model64 acc_valid", {79'd0, acc_valid64}, {79'd0, m_done});
    chk("model64 busy", {79'd0, busy64}, {79'd0, m_active});
    chk("model64 lost", {79'd0, lost64}, {79'd0, m_lost});
    chk("model64 acc_out", {16'd0, acc_out64}, {16'd0, m_sum[63:0]});
    chk("model64 ovf", {79'd0, ovf64}, {79'd0, (|m_sum[79:64])});
  endtask

  // Apply one cycle of inputs, advance the model across the same edge, then
  // sample outputs 1 time unit after the edge.
  task automatic step(input logic r, input logic c, input logic v,
                      input logic [63:0] p, input logic [7:0] bl, input logic rd);
    reset = r; acc_clear = c; valid = v; prod = p; burst_len = bl; acc_ready = rd;
    @(posedge clk);
    model_update(r, c, v, p, bl, rd);
    #1;
    model_check();
  endtask

  typedef struct {
    logic        rst, clr, v;
    logic [63:0] p;
    logic [7:0]  bl;
    logic        rdy;
    logic        ev, eb, el;
    logic [71:0] ea;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic c, input logic v,
                         input logic [63:0] p, input logic [7:0] bl, input logic rd,
                         input logic ev, input logic eb, input logic el,
                         input logic [71:0] ea);
    vec_t t;
    t.rst = r; t.clr = c; t.v = v; t.p = p; t.bl = bl; t.rdy = rd;
    t.ev = ev; t.eb = eb; t.el = el; t.ea = ea;
    vecs.push_back(t);
  endtask

  initial begin
    // Directed table:  rst clr v  prod         bl  rdy | ev eb el acc_out
    add_vec(1,0,0, 64'd0,      8'd1, 0,  0,0,0, 72'd0);       // reset state
    add_vec(0,0,0, 64'd0,      8'd1, 0,  0,0,0, 72'd0);
    // single product
    add_vec(0,0,1, 64'd290862, 8'd1, 0,  1,1,0, 72'd290862);
    add_vec(0,0,0, 64'd0,      8'd1, 1,  0,0,0, 72'd290862);
    // burst of 3 back-to-back; burst_len changes after first are ignored
    add_vec(0,0,1, 64'd290862, 8'd3, 0,  0,1,0, 72'd290862);
    add_vec(0,0,1, 64'd1,      8'd0, 0,  0,1,0, 72'd290863);
    add_vec(0,0,1, 64'd2,      8'd9, 0,  1,1,0, 72'd290865);
    for (int i = 0; i < 5; i++)
      add_vec(0,0,0, 64'd0,    8'd1, 0,  1,1,0, 72'd290865);  // held
    add_vec(0,0,0, 64'd0,      8'd1, 1,  0,0,0, 72'd290865);
    // gapped burst of 4, then products during DONE
    add_vec(0,0,1, 64'd10,     8'd4, 0,  0,1,0, 72'd10);
    add_vec(0,0,0, 64'd0,      8'd4, 0,  0,1,0, 72'd10);
    add_vec(0,0,1, 64'd20,     8'd4, 0,  0,1,0, 72'd30);
    add_vec(0,0,0, 64'd0,      8'd4, 0,  0,1,0, 72'd30);
    add_vec(0,0,1, 64'd30,     8'd4, 0,  0,1,0, 72'd60);
    add_vec(0,0,0, 64'd0,      8'd4, 0,  0,1,0, 72'd60);
    add_vec(0,0,1, 64'd40,     8'd4, 0,  1,1,0, 72'd100);
    add_vec(0,0,1, 64'd5,      8'd4, 0,  1,1,1, 72'd100);     // lost
    add_vec(0,0,1, 64'd5,      8'd4, 1,  0,0,1, 72'd100);     // lost on handshake
    add_vec(0,0,0, 64'd0,      8'd1, 0,  0,0,1, 72'd100);     // lost sticks
    add_vec(0,0,1, 64'd3,      8'd1, 0,  1,1,1, 72'd3);
    add_vec(0,0,0, 64'd0,      8'd1, 1,  0,0,1, 72'd3);
    add_vec(0,0,1, 64'd4,      8'd1, 0,  1,1,1, 72'd4);       // first IDLE cycle accepts
    add_vec(0,1,1, 64'd6,      8'd1, 0,  0,0,0, 72'd0);       // clear drops valid
    add_vec(0,0,0, 64'd0,      8'd1, 0,  0,0,0, 72'd0);
    // abort with acc_clear after 2 of 4
    add_vec(0,0,1, 64'd7,      8'd4, 0,  0,1,0, 72'd7);
    add_vec(0,0,1, 64'd8,      8'd4, 0,  0,1,0, 72'd15);
    add_vec(0,1,0, 64'd0,      8'd4, 0,  0,0,0, 72'd0);
    add_vec(0,0,1, 64'd9,      8'd1, 0,  1,1,0, 72'd9);
    add_vec(0,0,0, 64'd0,      8'd1, 1,  0,0,0, 72'd9);
    // abort with reset after 2 of 4
    add_vec(0,0,1, 64'd7,      8'd4, 0,  0,1,0, 72'd7);
    add_vec(0,0,1, 64'd8,      8'd4, 0,  0,1,0, 72'd15);
    add_vec(1,0,0, 64'd0,      8'd4, 0,  0,0,0, 72'd0);
    add_vec(0,0,1, 64'd9,      8'd1, 0,  1,1,0, 72'd9);
    add_vec(0,0,0, 64'd0,      8'd1, 1,  0,0,0, 72'd9);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].clr, vecs[i].v, vecs[i].p, vecs[i].bl, vecs[i].rdy);
      chk($sformatf("vec%0d acc_valid", i), {79'd0, acc_valid}, {79'd0, vecs[i].ev});
      chk($sformatf("vec%0d busy", i), {79'd0, busy}, {79'd0, vecs[i].eb});
      chk($sformatf("vec%0d lost", i), {79'd0, lost}, {79'd0, vecs[i].el});
      chk($sformatf("vec%0d acc_out", i), {8'd0, acc_out}, {8'd0, vecs[i].ea});
      chk($sformatf("vec%0d ovf", i), {79'd0, ovf}, 80'd0);
      chk($sformatf("vec%0d acc_out64", i), {16'd0, acc_out64}, {16'd0, vecs[i].ea[63:0]});
      chk($sformatf("vec%0d acc_valid64", i), {79'd0, acc_valid64}, {79'd0, vecs[i].ev});
    end

    // Overflow on the 64-bit instance: (2^64-1) + 2 wraps to 1.
    step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'd2, 0);
    step(0, 0, 1, 64'd2, 8'd2, 0);
    chk("ovf64 acc_valid", {79'd0, acc_valid64}, 80'd1);
    chk("ovf64 acc_out", {16'd0, acc_out64}, 80'd1);
    chk("ovf64 ovf", {79'd0, ovf64}, 80'd1);
    chk("ovf72 acc_out", {8'd0, acc_out}, 80'h01_0000_0000_0000_0001);
    chk("ovf72 ovf", {79'd0, ovf}, 80'd0);
    step(0, 0, 0, 64'd0, 8'd1, 1);
    step(0, 0, 1, 64'd5, 8'd1, 0);
    chk("ovf64 next acc_out", {16'd0, acc_out64}, 80'd5);
    chk("ovf64 next ovf", {79'd0, ovf64}, 80'd0);
    step(0, 0, 0, 64'd0, 8'd1, 1);

    // burst_len=0: 256 products of 1, result exactly one cycle after the last.
    for (int i = 0; i < 256; i++) begin
      step(0, 0, 1, 64'd1, 8'd0, 0);
      chk($sformatf("len0 acc_valid after %0d", i + 1), {79'd0, acc_valid},
          (i == 255) ? 80'd1 : 80'd0);
    end
    chk("len0 acc_out", {8'd0, acc_out}, 80'd256);
    step(0, 0, 0, 64'd0, 8'd0, 1);

    // 256 full-scale products: fits in 72 bits, wraps in 64 bits.
    for (int i = 0; i < 256; i++) step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'd0, 0);
    chk("full acc_valid", {79'd0, acc_valid}, 80'd1);
    chk("full acc_out", {8'd0, acc_out}, 80'h00_FF_FFFF_FFFF_FFFF_FF00);
    chk("full ovf", {79'd0, ovf}, 80'd0);
    chk("full64 acc_out", {16'd0, acc_out64}, 80'h0000_FFFF_FFFF_FFFF_FF00);
    chk("full64 ovf", {79'd0, ovf64}, 80'd1);
    step(0, 0, 0, 64'd0, 8'd0, 1);

    // Randomized traffic, checked every cycle by the model inside step().
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] p;
      logic [7:0]  bl;
      case ($urandom_range(0, 3))
        0:       p = {$urandom, $urandom};
        1:       p = 64'hFFFF_FFFF_FFFF_FFFF;
        2:       p = 64'($urandom_range(0, 15));
        default: p = {$urandom, $urandom} | 64'hF000_0000_0000_0000;
      endcase
      bl = ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) < 7), p, bl, ($urandom_range(0, 1) == 1));
    end

    step(0, 1, 0, 64'd0, 8'd1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
